// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0]  SC_EXT    = 8'hE0;
    localparam logic [7:0]  SC_BRK    = 8'hF0;

    localparam logic [15:0] KEY_ENTER = 16'd128;
    localparam logic [15:0] KEY_BKSP  = 16'd129;
    localparam logic [15:0] KEY_LEFT  = 16'd130;
    localparam logic [15:0] KEY_UP    = 16'd131;
    localparam logic [15:0] KEY_RIGHT = 16'd132;
    localparam logic [15:0] KEY_DOWN  = 16'd133;
    localparam logic [15:0] KEY_ESC   = 16'd140;

    localparam logic [14:0] KBD_ADDR  = 15'h6000;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: pad synchronisers, ps2_clk glitch filter, frame FSM and
// mid-frame timeout. Emits one byte per good frame or an error pulse.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    logic                   filt_q,  filt_d;
    logic [FCNT_W-1:0]      fcnt_q,  fcnt_d;
    logic                   fe_q,    fe_d;

    rx_state_e              state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q,   par_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]             scan_code_d;
    logic                   scan_valid_d;
    logic                   frame_err_d;
    logic                   timeout_c;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Synchronisers and filter state, idling high like the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            fe_q      <= 1'b0;
        end else begin
            clk_sync  <= (clk_sync << 1)  | SYNC_STAGES'(ps2_clk);
            data_sync <= (data_sync << 1) | SYNC_STAGES'(ps2_data);
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            fe_q      <= fe_d;
        end
    end

    // Filtered level flips on the FILTER_LEN-th consecutive differing sample
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fe_d   = 1'b0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
                fe_d   = filt_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            scan_code  <= scan_code_d;
            scan_valid <= scan_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    assign timeout_c = (state_q != IDLE) && (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));

    // Frame FSM; a timeout overrides a coincident falling edge
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        scan_code_d  = scan_code;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE || fe_q) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (timeout_c) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            to_cnt_d    = '0;
        end else if (fe_q) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d   = {data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s && (^{shreg_q, par_q})) begin
                        scan_code_d  = shreg_q;
                        scan_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard controller: decodes E0/F0 prefixes and maps set-2 scancodes
// to Hack key codes held on key_code for the keyboard register.
module ps2_keyboard_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic [7:0]  scan_code,
    output logic        scan_valid,
    output logic        frame_err
);

    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [15:0] key_d;
    logic [15:0] map_c;
    logic        mapped_c;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    // Set-2 keymap; only the arrows are mapped behind an E0 prefix
    always_comb begin
        map_c    = '0;
        mapped_c = 1'b1;
        if (ext_q) begin
            case (scan_code)
                8'h6B:   map_c = KEY_LEFT;
                8'h75:   map_c = KEY_UP;
                8'h74:   map_c = KEY_RIGHT;
                8'h72:   map_c = KEY_DOWN;
                default: mapped_c = 1'b0;
            endcase
        end else begin
            case (scan_code)
                8'h1C: map_c = 16'd65;  8'h32: map_c = 16'd66;
                8'h21: map_c = 16'd67;  8'h23: map_c = 16'd68;
                8'h24: map_c = 16'd69;  8'h2B: map_c = 16'd70;
                8'h34: map_c = 16'd71;  8'h33: map_c = 16'd72;
                8'h43: map_c = 16'd73;  8'h3B: map_c = 16'd74;
                8'h42: map_c = 16'd75;  8'h4B: map_c = 16'd76;
                8'h3A: map_c = 16'd77;  8'h31: map_c = 16'd78;
                8'h44: map_c = 16'd79;  8'h4D: map_c = 16'd80;
                8'h15: map_c = 16'd81;  8'h2D: map_c = 16'd82;
                8'h1B: map_c = 16'd83;  8'h2C: map_c = 16'd84;
                8'h3C: map_c = 16'd85;  8'h2A: map_c = 16'd86;
                8'h1D: map_c = 16'd87;  8'h22: map_c = 16'd88;
                8'h35: map_c = 16'd89;  8'h1A: map_c = 16'd90;
                8'h45: map_c = 16'd48;  8'h16: map_c = 16'd49;
                8'h1E: map_c = 16'd50;  8'h26: map_c = 16'd51;
                8'h25: map_c = 16'd52;  8'h2E: map_c = 16'd53;
                8'h36: map_c = 16'd54;  8'h3D: map_c = 16'd55;
                8'h3E: map_c = 16'd56;  8'h46: map_c = 16'd57;
                8'h29: map_c = 16'd32;
                8'h5A: map_c = KEY_ENTER;
                8'h66: map_c = KEY_BKSP;
                8'h76: map_c = KEY_ESC;
                default: mapped_c = 1'b0;
            endcase
        end
    end

    // Prefix decoder: a break only releases the key currently held
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        key_d = key_code;
        if (scan_valid) begin
            if (scan_code == SC_EXT) begin
                ext_d = 1'b1;
            end else if (scan_code == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (mapped_c) begin
                    if (!brk_q) begin
                        key_d = map_c;
                    end else if (map_c == key_code) begin
                        key_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            key_code <= '0;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            key_code <= key_d;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Directed bench for ps2_keyboard_ctrl with a queue-based scoreboard monitor.
module tb_ps2_keyboard_ctrl;

    localparam int unsigned HP = 20;
    localparam int unsigned TO = 1000;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] key_code;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  code;
        logic [15:0] key;
    } exp_t;

    exp_t        exp_q[$];
    bit          pend_key = 0;
    logic [15:0] pend_val;

    ps2_keyboard_ctrl #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expectation per scan_valid / frame_err pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_key) begin
                checks++;
                if (key_code !== pend_val) begin
                    errors++;
                    $display("FAIL key_code after scan: got %0d expected %0d", key_code, pend_val);
                end
                pend_key = 0;
            end
            if (scan_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected event: scan_valid=%0b frame_err=%0b scan_code=%h",
                             scan_valid, frame_err, scan_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        checks++;
                        if (!frame_err || scan_valid) begin
                            errors++;
                            $display("FAIL frame_err event: got err=%0b valid=%0b expected err=1 valid=0",
                                     frame_err, scan_valid);
                        end
                        checks++;
                        if (key_code !== e.key) begin
                            errors++;
                            $display("FAIL key_code on error: got %0d expected %0d", key_code, e.key);
                        end
                    end else begin
                        checks++;
                        if (!scan_valid || frame_err || scan_code !== e.code) begin
                            errors++;
                            $display("FAIL scan event: got valid=%0b err=%0b code=%h expected valid=1 err=0 code=%h",
                                     scan_valid, frame_err, scan_code, e.code);
                        end
                        pend_key = 1;
                        pend_val = e.key;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HP / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HP / 2) @(negedge clk);
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par_flip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_flip);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic expect_scan(input logic [7:0] d, input logic [15:0] key);
        exp_t e;
        e.is_err = 0;
        e.code   = d;
        e.key    = key;
        exp_q.push_back(e);
        send_raw(d, 1'b0, 1'b1);
    endtask

    task automatic expect_err(input logic [7:0] d, input logic par_flip, input logic stop,
                              input logic [15:0] key);
        exp_t e;
        e.is_err = 1;
        e.code   = d;
        e.key    = key;
        exp_q.push_back(e);
        send_raw(d, par_flip, stop);
    endtask

    task automatic expect_timeout(input logic [15:0] key);
        exp_t e;
        e.is_err = 1;
        e.code   = 8'h00;
        e.key    = key;
        exp_q.push_back(e);
        send_partial(4);
        repeat (TO + 200) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset key_code",   key_code,           16'h0000);
        check("reset scan_code",  16'(scan_code),     16'h0000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset scan_valid", 16'(scan_valid),    16'h0000);
        check("reset frame_err",  16'(frame_err),     16'h0000);

        // Make and break of A
        expect_scan(8'h1C, 16'h0041);
        expect_scan(8'hF0, 16'h0041);
        expect_scan(8'h1C, 16'h0000);

        // Short ps2_clk glitch with data low must not start a frame
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (TO + 200) @(negedge clk);

        // Extended up arrow make and break
        expect_scan(8'hE0, 16'h0000);
        expect_scan(8'h75, 16'd131);
        expect_scan(8'hE0, 16'd131);
        expect_scan(8'hF0, 16'd131);
        expect_scan(8'h75, 16'h0000);

        // Rollover: B replaces A, stale break of A ignored
        expect_scan(8'h1C, 16'h0041);
        expect_scan(8'h32, 16'h0042);
        expect_scan(8'hF0, 16'h0042);
        expect_scan(8'h1C, 16'h0042);
        expect_scan(8'hF0, 16'h0042);
        expect_scan(8'h32, 16'h0000);

        // Typematic repeat keeps the code
        expect_scan(8'h1C, 16'h0041);
        expect_scan(8'h1C, 16'h0041);

        // Bad parity and bad stop bit
        expect_err(8'h1C, 1'b1, 1'b1, 16'h0041);
        expect_err(8'h1C, 1'b0, 1'b0, 16'h0041);

        // Unmapped codes, including a non-arrow behind E0
        expect_scan(8'h05, 16'h0041);
        expect_scan(8'h75, 16'h0041);
        expect_scan(8'hE0, 16'h0041);
        expect_scan(8'hF0, 16'h0041);
        expect_scan(8'h1C, 16'h0041);
        expect_scan(8'hF0, 16'h0041);
        expect_scan(8'h1C, 16'h0000);

        // Mid-frame timeout, then space
        expect_timeout(16'h0000);
        expect_scan(8'h29, 16'd32);

        // Frame error between E0 and its byte keeps the prefix
        expect_scan(8'hE0, 16'd32);
        expect_err(8'h75, 1'b1, 1'b1, 16'd32);
        expect_scan(8'h75, 16'd131);

        // Reset mid-frame
        send_partial(3);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid-frame reset key_code",   key_code,        16'h0000);
        check("mid-frame reset scan_code",  16'(scan_code),  16'h0000);
        check("mid-frame reset scan_valid", 16'(scan_valid), 16'h0000);
        check("mid-frame reset frame_err",  16'(frame_err),  16'h0000);
        repeat (20) @(negedge clk);
        expect_scan(8'h29, 16'd32);

        repeat (100) @(negedge clk);
        check("pending expectations", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
